ser_word_loader: RTL and testbench

SER_WORD_LOADER -- requirements
Module: ser_word_loader

---
 rtl/ser_word_pkg.sv | 5 +
 rtl/ser_word_loader.sv | 67 ++++++
 tb/tb_ser_word_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ser_word_pkg.sv
// ser_word_pkg: shared FSM state type and default word width for the serial word loader.
package ser_word_pkg;
    localparam int W_DEFAULT = 16;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
endpackage

// File: rtl/ser_word_loader.sv
// ser_word_loader: assembles MSB-first serial bits into a W-bit word and strobes it into a downstream register.
module ser_word_loader
    import ser_word_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk50m,
    input  logic         rst_n,
    input  logic         sdi,
    input  logic         sdi_valid,
    input  logic         frame,
    output logic [W-1:0] d,
    output logic         load,
    output logic         en,
    output logic         busy,
    output logic         frame_err,
    output logic [7:0]   word_cnt
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W);
    state_t state, state_nx;
    logic [W-1:0] shift, shift_nx, d_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic err_nx;
    assign load = state == LOAD;
    assign en = state == LOAD;
    assign busy = state != IDLE;
    // IDLE and LOAD both start a fresh word, so only SHIFT carries the count forward
    always_comb begin
        state_nx = state;
        shift_nx = shift;
        d_nx = d;
        cnt_nx = cnt;
        err_nx = 1'b0;
        cnt_inc = (state == SHIFT ? cnt : '0) + 1'b1;
        if (!frame) begin
            state_nx = IDLE;
            cnt_nx = '0;
            err_nx = (state == SHIFT) && (cnt != '0);
        end else if (sdi_valid) begin
            shift_nx = {shift[W-2:0], sdi};
            state_nx = cnt_inc == LAST ? LOAD : SHIFT;
            cnt_nx = cnt_inc == LAST ? '0 : cnt_inc;
            d_nx = cnt_inc == LAST ? shift_nx : d;
        end else begin
            state_nx = SHIFT;
            cnt_nx = state == SHIFT ? cnt : '0;
        end
    end
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shift <= '0;
            d <= '0;
            cnt <= '0;
            frame_err <= 1'b0;
            word_cnt <= '0;
        end else begin
            state <= state_nx;
            shift <= shift_nx;
            d <= d_nx;
            cnt <= cnt_nx;
            frame_err <= err_nx;
            if (state == LOAD) word_cnt <= word_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ser_word_loader.sv
// tb_ser_word_loader: scoreboard bench; words are queued when driven and checked on each load strobe.
module tb_ser_word_loader;
    import ser_word_pkg::*;
    localparam int W = W_DEFAULT;
    logic clk50m = 1'b0, rst_n = 1'b0, sdi = 1'b0, sdi_valid = 1'b0, frame = 1'b0;
    logic [W-1:0] d;
    logic load, en, busy, frame_err;
    logic [7:0] word_cnt;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_d;
    logic [7:0] exp_cnt = '0;
    int n_chk = 0, n_pass = 0, n_load = 0, n_err = 0, cyc = 0, last_load_cyc = 0, load_gap = 0;

    always #10 clk50m = ~clk50m;

    ser_word_loader #(.W(W)) dut (
        .clk50m(clk50m), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid), .frame(frame),
        .d(d), .load(load), .en(en), .busy(busy), .frame_err(frame_err), .word_cnt(word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk50m);
        #2;
    endtask

    task automatic shift_bits(input logic [W-1:0] w, input int n, input bit gap);
        frame = 1'b1;
        for (int i = W - 1; i >= W - n; i--) begin
            sdi = w[i];
            sdi_valid = 1'b1;
            tick();
            if (gap) begin
                sdi_valid = 1'b0;
                sdi = ~sdi;
                tick();
            end
        end
        sdi_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gap);
        exp_q.push_back(w);
        shift_bits(w, W, gap);
    endtask

    always @(negedge clk50m) begin
        cyc++;
        if (!rst_n) exp_cnt = '0;
        if (frame_err) n_err++;
        if (load) begin
            n_load++;
            load_gap = cyc - last_load_cyc;
            last_load_cyc = cyc;
            chk("en_with_load", en, 1);
            chk("word_cnt_at_load", word_cnt, exp_cnt);
            chk("load_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_d = exp_q.pop_front();
                chk("d_at_load", d, exp_d);
            end
            exp_cnt++;
        end
    end

    initial begin
        #65;
        chk("rst_d", d, 0);
        chk("rst_load", load, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_word_cnt", word_cnt, 0);
        @(negedge clk50m);
        rst_n = 1'b1;
        tick();
        sdi = 1'b1;
        sdi_valid = 1'b1;
        repeat (3) tick();
        sdi_valid = 1'b0;
        chk("idle_valid_busy", busy, 0);
        frame = 1'b1;
        repeat (2) tick();
        chk("empty_frame_busy", busy, 1);
        frame = 1'b0;
        repeat (2) tick();
        chk("empty_frame_err", n_err, 0);
        chk("empty_frame_idle", busy, 0);
        send_word(16'hA5C3, 1'b0);
        frame = 1'b0;
        repeat (2) tick();
        chk("single_d", d, 16'hA5C3);
        chk("single_cnt", word_cnt, 1);
        chk("single_loads", n_load, 1);
        send_word(16'h0000, 1'b0);
        send_word(16'hFFFF, 1'b0);
        frame = 1'b0;
        repeat (2) tick();
        chk("b2b_gap", load_gap, W);
        chk("b2b_d", d, 16'hFFFF);
        chk("b2b_cnt", word_cnt, 3);
        shift_bits(16'h5A5A, 7, 1'b0);
        chk("abort_busy_mid", busy, 1);
        frame = 1'b0;
        sdi_valid = 1'b1;
        tick();
        sdi_valid = 1'b0;
        repeat (3) tick();
        chk("abort_err_pulses", n_err, 1);
        chk("abort_loads", n_load, 3);
        chk("abort_d_held", d, 16'hFFFF);
        chk("abort_idle", busy, 0);
        send_word(16'h1234, 1'b1);
        frame = 1'b0;
        repeat (2) tick();
        chk("gapped_d", d, 16'h1234);
        chk("gapped_loads", n_load, 4);
        chk("gapped_cnt", word_cnt, 4);
        shift_bits(16'hBEEF, 10, 1'b0);
        rst_n = 1'b0;
        frame = 1'b0;
        #30;
        chk("midrst_d", d, 0);
        chk("midrst_cnt", word_cnt, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk50m);
        rst_n = 1'b1;
        tick();
        send_word(16'h00FF, 1'b0);
        frame = 1'b0;
        repeat (2) tick();
        chk("midrst_loads", n_load, 5);
        chk("after_rst_d", d, 16'h00FF);
        chk("after_rst_cnt", word_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("total_err_pulses", n_err, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
